// File: rtl/tpu_matmul_core_pkg.sv
// Shared widths, sequencer phase type and element-indexing helpers for the
// 2x2 matrix-multiply core.
package tpu_matmul_core_pkg;

  localparam int ELEM_W = 4;
  localparam int N_ELEM = 4;
  localparam int WORD_W = ELEM_W * N_ELEM;
  localparam logic [1:0] LAST_ELEM = 2'(N_ELEM - 1);

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  // Row-major slot of M[row][col] inside a packed word.
  function automatic logic [1:0] elem_idx(input int row, input int col);
    return 2'(row * 2 + col);
  endfunction

  function automatic logic [ELEM_W-1:0] get_elem(input logic [WORD_W-1:0] word,
                                                 input logic [1:0] idx);
    return word[int'(idx) * ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/tpu_matmul_core_word_assembler.sv
// Collects four 4-bit elements, one per strobe, into a packed 2x2 word and
// pulses flat_comple for one cycle when a word completes.
module tpu_word_assembler
  import tpu_matmul_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        dato,
  input  logic              rx_flat,
  output logic [WORD_W-1:0] data_comple,
  output logic              flat_comple
);

  logic [1:0]        counter;
  logic [WORD_W-1:0] slots;
  logic [WORD_W-1:0] word_next;
  logic              unused_hi;

  assign unused_hi = ^dato[7:ELEM_W];

  always_comb begin
    word_next = slots;
    word_next[int'(counter) * ELEM_W +: ELEM_W] = dato[ELEM_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter     <= '0;
      slots       <= '0;
      data_comple <= '0;
      flat_comple <= 1'b0;
    end else begin
      flat_comple <= 1'b0;
      if (rx_flat) begin
        slots   <= word_next;
        counter <= counter + 2'd1;
        if (counter == LAST_ELEM) begin
          data_comple <= word_next;
          flat_comple <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tpu_matmul_core.sv
// 2x2 matrix-multiply core: first completed word becomes A, the second is B,
// A x B (mod 16 per element) is registered and can be accumulated.
module tpu_matmul_core
  import tpu_matmul_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        dato,
  input  logic              rx_flat,
  input  logic              accu_en,
  input  logic              clear,
  output logic [WORD_W-1:0] data_comple,
  output logic              flat_comple,
  output logic [WORD_W-1:0] result,
  output logic              listo,
  output logic [WORD_W-1:0] out
);

  phase_t            phase;
  logic              mm_en;
  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] prod;
  logic [WORD_W-1:0] acc_next;

  tpu_word_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .dato       (dato),
    .rx_flat    (rx_flat),
    .data_comple(data_comple),
    .flat_comple(flat_comple)
  );

  // B is never copied: data_comple holds it until the next word completes.
  always_comb begin
    prod = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        prod[int'(elem_idx(r, c)) * ELEM_W +: ELEM_W] =
          ELEM_W'(get_elem(a_reg, elem_idx(r, 0)) * get_elem(data_comple, elem_idx(0, c)) +
                  get_elem(a_reg, elem_idx(r, 1)) * get_elem(data_comple, elem_idx(1, c)));
      end
    end
  end

  always_comb begin
    acc_next = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      acc_next[i * ELEM_W +: ELEM_W] =
        ELEM_W'(out[i * ELEM_W +: ELEM_W] + result[i * ELEM_W +: ELEM_W]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= PH_A;
      a_reg  <= '0;
      mm_en  <= 1'b0;
      result <= '0;
      listo  <= 1'b0;
      out    <= '0;
    end else begin
      mm_en <= 1'b0;
      listo <= 1'b0;
      if (flat_comple) begin
        if (phase == PH_A) begin
          a_reg <= data_comple;
          phase <= PH_B;
        end else begin
          phase <= PH_A;
          mm_en <= 1'b1;
        end
      end
      if (mm_en) begin
        result <= prod;
        listo  <= 1'b1;
      end
      if (clear) begin
        out <= '0;
      end else if (accu_en) begin
        out <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_tpu_matmul_core.sv
// Directed bench for tpu_matmul_core with hand-computed expected words.
module tb_tpu_matmul_core;

  logic        clk;
  logic        rst;
  logic [7:0]  dato;
  logic        rx_flat;
  logic        accu_en;
  logic        clear;
  logic [15:0] data_comple;
  logic        flat_comple;
  logic [15:0] result;
  logic        listo;
  logic [15:0] out;

  int vecCount = 0;
  int errCount = 0;

  tpu_matmul_core dut (
    .clk        (clk),
    .rst        (rst),
    .dato       (dato),
    .rx_flat    (rx_flat),
    .accu_en    (accu_en),
    .clear      (clear),
    .data_comple(data_comple),
    .flat_comple(flat_comple),
    .result     (result),
    .listo      (listo),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  // One write strobe; called 1ns after an edge, returns 1ns after the sampling edge.
  task applyStimulus(input logic [7:0] d);
    dato    = d;
    rx_flat = 1'b1;
    step();
    rx_flat = 1'b0;
  endtask

  task writeWord(input logic [15:0] w, input logic [3:0] hi);
    for (int i = 0; i < 4; i++) applyStimulus({hi, w[i*4 +: 4]});
  endtask

  task applyAccu(input logic a, input logic c);
    accu_en = a;
    clear   = c;
    step();
    accu_en = 1'b0;
    clear   = 1'b0;
  endtask

  task runMatmul(input logic [15:0] a, input logic [15:0] b,
                 input logic [15:0] exp, input logic [3:0] hi);
    writeWord(a, hi);
    checkOutput("a_word", data_comple, a);
    checkOutput("a_flat", {15'd0, flat_comple}, 16'd1);
    writeWord(b, hi);
    checkOutput("b_word", data_comple, b);
    checkOutput("b_flat", {15'd0, flat_comple}, 16'd1);
    checkOutput("listo_t0", {15'd0, listo}, 16'd0);
    step();
    checkOutput("flat_drop", {15'd0, flat_comple}, 16'd0);
    checkOutput("listo_t1", {15'd0, listo}, 16'd0);
    step();
    checkOutput("listo_t2", {15'd0, listo}, 16'd1);
    checkOutput("result", result, exp);
    step();
    checkOutput("listo_t3", {15'd0, listo}, 16'd0);
    checkOutput("result_hold", result, exp);
  endtask

  initial begin
    rst     = 1'b0;
    dato    = 8'h00;
    rx_flat = 1'b0;
    accu_en = 1'b0;
    clear   = 1'b0;
    #3;
    checkOutput("rst_data", data_comple, 16'h0000);
    checkOutput("rst_result", result, 16'h0000);
    checkOutput("rst_out", out, 16'h0000);
    checkOutput("rst_listo", {15'd0, listo}, 16'd0);
    step();
    rst = 1'b1;
    step();

    runMatmul(16'h4321, 16'h8765, 16'h2B63, 4'h0);

    applyAccu(1'b1, 1'b0);
    checkOutput("accu1", out, 16'h2B63);
    applyAccu(1'b1, 1'b0);
    checkOutput("accu2", out, 16'h46C6);
    applyAccu(1'b0, 1'b1);
    checkOutput("clear", out, 16'h0000);

    // accu_en on the edge that loads the new result must add the old one
    writeWord(16'h1001, 4'h0);
    writeWord(16'hFEDC, 4'h0);
    step();
    accu_en = 1'b1;
    step();
    accu_en = 1'b0;
    checkOutput("ident_listo", {15'd0, listo}, 16'd1);
    checkOutput("ident_result", result, 16'hFEDC);
    checkOutput("accu_prev", out, 16'h2B63);
    step();

    applyAccu(1'b1, 1'b1);
    checkOutput("clear_wins", out, 16'h0000);

    runMatmul(16'hFFFF, 16'hFFFF, 16'h2222, 4'hF);
    runMatmul(16'h1001, 16'h4123, 16'h4123, 4'hA);

    // reset with A latched and a partial word pending
    writeWord(16'h7777, 4'h0);
    applyStimulus(8'h09);
    applyStimulus(8'h09);
    rst = 1'b0;
    #2;
    checkOutput("midrst_data", data_comple, 16'h0000);
    checkOutput("midrst_result", result, 16'h0000);
    checkOutput("midrst_flat", {15'd0, flat_comple}, 16'd0);
    step();
    rst = 1'b1;
    step();
    runMatmul(16'h1001, 16'h5A3C, 16'h5A3C, 4'h0);
    applyAccu(1'b1, 1'b0);
    checkOutput("accu_after_rst", out, 16'h5A3C);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
